// File: rtl/lfsr_sched.sv
// lfsr_sched: round-robin burst scheduler in front of a shared LFSR.
// A granted requester receives a burst of pseudo-random words, and a seed
// load takes priority over arbitration whenever the scheduler is idle.
//
// Handshakes:
//   - A data word transfers on a rising edge where valid_o && ready_i.
//     While ready_i is low, data_o and valid_o hold and the LFSR is not
//     stepped.
//   - A seed transfers on a rising edge where seed_valid_i && seed_ready_o.
module lfsr_sched #(
    parameter int g_num_req   = 2,
    parameter int g_length    = 16,
    parameter int g_len_width = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [g_num_req-1:0]               req_i,
    input  logic [g_num_req*g_len_width-1:0]   len_i,
    output logic [g_num_req-1:0]               gnt_o,
    output logic [g_num_req-1:0]               done_o,
    output logic                               valid_o,
    input  logic                               ready_i,
    output logic [g_length-1:0]                data_o,
    output logic [1:0]                         chan_o,
    input  logic                               seed_valid_i,
    input  logic [g_length-1:0]                seed_i,
    output logic                               seed_ready_o,
    output logic                               lfsr_en_o,
    output logic                               lfsr_load_o,
    output logic [g_length-1:0]                lfsr_seed_o,
    input  logic [g_length-1:0]                lfsr_q_i,
    output logic [1:0]                         state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [g_num_req-1:0]     gnt_q, gnt_d;
    logic [1:0]               chan_q, chan_d;
    logic [1:0]               ptr_q, ptr_d;     // last granted requester
    logic [g_len_width:0]     cnt_q, cnt_d;     // one extra bit for 2^g_len_width

    logic [2*g_num_req-1:0]   req_dbl;
    logic [g_num_req-1:0]     req_rot;
    logic                     win_found;
    logic [2:0]               win_off;
    logic [2:0]               win_sum;
    logic [1:0]               win_idx;
    logic [g_len_width-1:0]   win_len;
    logic [g_num_req-1:0]     win_onehot;
    logic                     accept;

    assign accept = (state_q == S_BURST) && ready_i;

    // Round-robin pick: rotate requests so the search starts after the last winner.
    always_comb begin
        req_dbl    = {req_i, req_i} >> ({1'b0, ptr_q} + 3'd1);
        req_rot    = req_dbl[g_num_req-1:0];
        win_found  = 1'b0;
        win_off    = 3'd0;
        win_len    = '0;
        win_onehot = '0;
        for (int i = 0; i < g_num_req; i++) begin
            if (!win_found && req_rot[i]) begin
                win_found = 1'b1;
                win_off   = 3'(i);
            end
        end
        win_sum = {1'b0, ptr_q} + 3'd1 + win_off;
        if (win_sum >= 3'(g_num_req)) begin
            win_sum = win_sum - 3'(g_num_req);
        end
        win_idx = win_sum[1:0];
        for (int k = 0; k < g_num_req; k++) begin
            if (2'(k) == win_idx) begin
                win_len       = len_i[k*g_len_width +: g_len_width];
                win_onehot[k] = 1'b1;
            end
        end
    end

    // Next-state logic: seed load beats arbitration, bursts run to completion.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        chan_d  = chan_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (!seed_valid_i && win_found) begin
                    state_d = S_BURST;
                    gnt_d   = win_onehot;
                    chan_d  = win_idx;
                    ptr_d   = win_idx;
                    cnt_d   = (win_len == '0) ? {1'b1, {g_len_width{1'b0}}}
                                              : {1'b0, win_len};
                end
            end
            S_BURST: begin
                if (accept) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == {{g_len_width{1'b0}}, 1'b1}) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                chan_d  = 2'd0;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                chan_d  = 2'd0;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous reset; the pointer restarts at the last index.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            chan_q  <= 2'd0;
            ptr_q   <= 2'(g_num_req - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            chan_q  <= chan_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode the registered state; grant shows only during the burst.
    always_comb begin
        gnt_o        = (state_q == S_BURST) ? gnt_q : '0;
        done_o       = (state_q == S_DONE) ? gnt_q : '0;
        chan_o       = (state_q == S_BURST) ? chan_q : 2'd0;
        valid_o      = (state_q == S_BURST);
        data_o       = lfsr_q_i;
        seed_ready_o = (state_q == S_IDLE);
        lfsr_load_o  = (state_q == S_IDLE) && seed_valid_i;
        lfsr_en_o    = accept;
        lfsr_seed_o  = seed_i;
        state_o      = state_q;
    end

endmodule

// File: tb/tb_lfsr_sched.sv
// tb_lfsr_sched: directed scoreboard bench for lfsr_sched with a behavioural LFSR.
module tb_lfsr_sched;

  localparam int N = 2;
  localparam int L = 16;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] len;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           valid;
  logic           ready;
  logic [L-1:0]   data;
  logic [1:0]     chan;
  logic           seed_valid;
  logic [L-1:0]   seed;
  logic           seed_ready;
  logic           lfsr_en;
  logic           lfsr_load;
  logic [L-1:0]   lfsr_seed;
  logic [L-1:0]   lfsr_q;
  logic [1:0]     state;

  int errors = 0;
  int checks = 0;
  int en_cnt = 0;
  int gnt0_cnt = 0;

  logic [L+1:0]   exp_q[$];    // {chan, data} per accepted word
  logic [N-1:0]   done_q[$];
  logic [L-1:0]   exp_lfsr;
  logic           bp_pat [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  lfsr_sched #(.g_num_req(N), .g_length(L), .g_len_width(W)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .len_i(len), .gnt_o(gnt),
    .done_o(done), .valid_o(valid), .ready_i(ready), .data_o(data),
    .chan_o(chan), .seed_valid_i(seed_valid), .seed_i(seed),
    .seed_ready_o(seed_ready), .lfsr_en_o(lfsr_en), .lfsr_load_o(lfsr_load),
    .lfsr_seed_o(lfsr_seed), .lfsr_q_i(lfsr_q), .state_o(state)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [L-1:0] lfsr_next(input logic [L-1:0] x);
    return (x >> 1) ^ (x[0] ? 16'hb400 : 16'h0000);
  endfunction

  // Shared LFSR generator driven by the scheduler
  always @(posedge clk) begin
    if (rst) lfsr_q <= 16'h0001;
    else if (lfsr_load) lfsr_q <= lfsr_seed;
    else if (lfsr_en) lfsr_q <= lfsr_next(lfsr_q);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    done_q.delete();
    exp_lfsr = 16'h0001;
  endtask

  // Driver: queue the expected words/done for one burst and raise the request
  task automatic issue(input int ch, input int blen);
    int eff;
    eff = (blen == 0) ? (1 << W) : blen;
    for (int i = 0; i < eff; i++) begin
      exp_q.push_back({2'(ch), exp_lfsr});
      exp_lfsr = lfsr_next(exp_lfsr);
    end
    done_q.push_back(N'(1) << ch);
    len[ch*W +: W] = W'(blen);
    req[ch] = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0 || state != 2'd0) && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", 32'(n < budget), 32'd1);
  endtask

  // Monitor / scoreboard: compares every accepted word and done pulse
  task automatic monitor();
    logic [L+1:0] e;
    logic [N-1:0] d;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("en_load_excl", 32'(lfsr_en & lfsr_load), 32'd0);
        check("en_outside_burst", 32'(lfsr_en & ~valid), 32'd0);
        if (lfsr_en) en_cnt++;
        if (gnt == N'(1)) gnt0_cnt++;
        if (valid && ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("word_data", 32'(data), 32'(e[L-1:0]));
            check("word_chan", 32'(chan), 32'(e[L+1:L]));
            check("word_gnt", 32'(gnt), 32'(N'(1) << e[L+1:L]));
          end
        end else if (valid && exp_q.size() != 0) begin
          check("hold_data", 32'(data), 32'(exp_q[0][L-1:0]));
        end
        if (done != '0) begin
          if (done_q.size() == 0) begin
            check("unexpected_done", 32'(done), 32'd0);
          end else begin
            d = done_q.pop_front();
            check("done_bit", 32'(done), 32'(d));
            check("done_no_valid", 32'(valid), 32'd0);
          end
        end
      end
    end
  endtask

  initial begin
    int e0;
    int g0;
    int n;
    rst = 1'b1; req = '0; len = '0; ready = 1'b1;
    seed_valid = 1'b0; seed = '0; exp_lfsr = 16'h0001;
    fork
      monitor();
    join_none

    // Reset values while rst is held
    tick();
    tick();
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_chan", 32'(chan), 32'd0);
    check("rst_en", 32'(lfsr_en), 32'd0);
    check("rst_load", 32'(lfsr_load), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    reset_dut();

    // Single burst of 4
    e0 = en_cnt; g0 = gnt0_cnt;
    issue(0, 4);
    tick();
    req = '0;
    drain(50);
    check("single_en_count", 32'(en_cnt - e0), 32'd4);
    check("single_gnt_cycles", 32'(gnt0_cnt - g0), 32'd4);

    // Fairness: both requesting, length 2, from the reset pointer
    reset_dut();
    issue(0, 2); issue(1, 2); issue(0, 2); issue(1, 2);
    n = 0;
    for (int c = 0; c < 80 && n < 4; c++) begin
      @(negedge clk);
      if (done != '0) n++;
    end
    req = '0;
    check("fair_done_pulses", 32'(n), 32'd4);
    drain(50);

    // Backpressure: ready toggles 1,0,1,0,1
    e0 = en_cnt;
    issue(0, 3);
    tick();
    req = '0;
    for (int i = 0; i < 5; i++) begin
      ready = bp_pat[i];
      tick();
    end
    ready = 1'b1;
    drain(50);
    check("bp_en_count", 32'(en_cnt - e0), 32'd3);

    // Seed priority over a simultaneous request
    exp_lfsr = 16'hace1;
    issue(0, 2);
    seed_valid = 1'b1;
    seed = 16'hace1;
    @(negedge clk);
    check("seed_load", 32'(lfsr_load), 32'd1);
    check("seed_ready", 32'(seed_ready), 32'd1);
    check("seed_seed_out", 32'(lfsr_seed), 32'h0000ace1);
    check("seed_en_off", 32'(lfsr_en), 32'd0);
    tick();
    seed_valid = 1'b0;
    @(negedge clk);
    check("seed_no_grant", 32'(gnt), 32'd0);
    check("seed_still_idle", 32'(valid), 32'd0);
    tick();
    req = '0;
    drain(50);

    // Length field zero means 256 words
    e0 = en_cnt;
    issue(0, 0);
    tick();
    req = '0;
    drain(400);
    check("len0_en_count", 32'(en_cnt - e0), 32'd256);

    // Reset in the middle of a 5-word burst, after 2 words
    issue(0, 5);
    tick();
    req = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("abort_gnt", 32'(gnt), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_en", 32'(lfsr_en), 32'd0);
    check("abort_chan", 32'(chan), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    done_q.delete();
    exp_lfsr = 16'h0001;
    @(negedge clk);
    check("abort_seed_ready", 32'(seed_ready), 32'd1);
    issue(1, 2);
    tick();
    req = '0;
    drain(50);

    // After a fresh reset requester 0 wins a tie again
    reset_dut();
    issue(0, 1);
    len[W +: W] = 8'd1;
    req[1] = 1'b1;
    tick();
    req = '0;
    drain(50);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("done_q_empty", 32'(done_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lfsr_sched.md
LFSR_SCHED -- requirements
Module: lfsr_sched

Interface
Parameters:
REQ-001 The block SHALL have parameter g_num_req, default 2, number of requesters (legal 2..4).
REQ-002 The block SHALL have parameter g_length, default 16, width of the shared LFSR state/output word.
REQ-003 The block SHALL have parameter g_len_width, default 8, width of each burst-length field.

Ports:
REQ-004 clk_i  in  1  single clock; all logic on rising edge.
REQ-005 rst_i  in  1  synchronous, active-high reset.
REQ-006 req_i  in  g_num_req  per-requester burst request, level.
REQ-007 len_i  in  g_num_req*g_len_width  packed burst lengths; field k = bits [k*g_len_width +: g_len_width].
REQ-008 gnt_o  out  g_num_req  one-hot grant, held for whole burst.
REQ-009 done_o  out  g_num_req  one-hot, one-cycle pulse at burst completion.
REQ-010 valid_o  out  1  data_o holds a word for the granted requester.
REQ-011 ready_i  in  1  consumer accepts word when valid_o && ready_i.
REQ-012 data_o  out  g_length  pseudo-random word, equal to lfsr_q_i.
REQ-013 chan_o  out  2  binary index of granted requester; 0 when idle.
REQ-014 seed_valid_i  in  1  request to reseed the shared LFSR.
REQ-015 seed_i  in  g_length  seed value.
REQ-016 seed_ready_o  out  1  seed accepted this cycle when seed_valid_i && seed_ready_o.
REQ-017 lfsr_en_o  out  1  advance the shared LFSR generator by one step (its enable_i).
REQ-018 lfsr_load_o  out  1  load lfsr_seed_o into the shared LFSR.
REQ-019 lfsr_seed_o  out  g_length  seed passed to the LFSR, equal to seed_i.
REQ-020 lfsr_q_i  in  g_length  current registered LFSR output.

Function
REQ-021 The FSM SHALL have states IDLE, BURST, DONE.
REQ-022 IDLE: seed_ready_o=1; lfsr_load_o = seed_valid_i; in other states seed_ready_o=0, lfsr_load_o=0.
REQ-023 IDLE with seed_valid_i=1 SHALL NOT grant in that cycle; arbitration resumes next cycle (seed load has priority).
REQ-024 IDLE with any req_i bit set and seed_valid_i=0 SHALL select the winner round-robin, register gnt_o/chan_o, load the word counter from that requester's len_i field, and go to BURST next cycle.
REQ-025 Round-robin: search starts at index (last granted + 1) mod g_num_req; after reset last granted = g_num_req-1, so requester 0 has first priority.
REQ-026 Length field value 0 SHALL mean 2^g_len_width words; otherwise the value is the word count.
REQ-027 BURST: valid_o=1, data_o=lfsr_q_i, lfsr_en_o = ready_i; counter decrements on each accepted word.
REQ-028 valid_o and data_o SHALL remain stable while ready_i=0 (LFSR not advanced).
REQ-029 Accept of the last word (counter=1) SHALL move to DONE; DONE drives done_o bit of the granted requester for exactly one cycle, valid_o=0, then returns to IDLE with gnt_o=0.
REQ-030 Latency: req_i sampled in IDLE at cycle N -> gnt_o and valid_o asserted at N+1; burst of L words with ready_i=1 throughout -> done_o at N+1+L, next grant possible at N+2+L earliest.
REQ-031 req_i or len_i changes during BURST SHALL be ignored; the burst runs to completion.
REQ-032 The same requester MAY win consecutive bursts only if no other requester is asserting in the arbitration cycle.
REQ-033 lfsr_en_o SHALL never be asserted outside BURST; lfsr_en_o and lfsr_load_o SHALL never be asserted together.

Reset
REQ-034 While rst_i=1 at a clock edge: state IDLE, gnt_o=0, done_o=0, valid_o=0, chan_o=0, lfsr_en_o=0, lfsr_load_o=0, counter=0, round-robin pointer = g_num_req-1.
REQ-035 Reset asserted mid-burst SHALL abort the burst with no done_o pulse; seed_ready_o=1 from the first cycle after reset is released.

Verification
REQ-036 Single burst: req_i=01, len field0=4, ready_i=1 -> gnt_o=01 for 4 cycles, 4 accepted words equal to 4 successive LFSR states, done_o=01 one cycle, lfsr_en_o high exactly 4 cycles.
REQ-037 Fairness: req_i=11 held, both lengths 2 -> grants alternate 01,10,01,10; chan_o 0,1,0,1.
REQ-038 Backpressure: len=3, ready_i toggling 1,0,1,0,1 -> data_o stable during ready_i=0, exactly 3 lfsr_en_o pulses, done_o after third accept.
REQ-039 Seed priority: seed_valid_i=1 with seed_i=16'hace1 and req_i=01 in same IDLE cycle -> lfsr_load_o=1, no grant that cycle; grant next cycle, first data_o=16'hace1 (given LFSR loaded).
REQ-040 Length zero: len field0=0, g_len_width=8 -> exactly 256 accepted words before done_o.
REQ-041 Reset mid-burst: rst_i=1 after 2 of 5 words -> all outputs at reset values next cycle, no done_o, next req_i=10 granted to requester 1... then requester 0 priority rules restart from pointer g_num_req-1.
